// File: rtl/uart_hex_formatter_pkg.sv
// Shared definitions for the hex line formatter: ASCII constants, FSM states
// and the nibble-to-ASCII conversion.
package uart_hex_formatter_pkg;

   localparam logic [7:0] CHAR_0    = 8'h30;
   localparam logic [7:0] CHAR_X    = 8'h78;
   localparam logic [7:0] CHAR_CR   = 8'h0D;
   localparam logic [7:0] CHAR_LF   = 8'h0A;
   localparam logic [7:0] CHAR_A_UC = 8'h41;
   localparam logic [7:0] CHAR_A_LC = 8'h61;

   // State names the byte currently presented on o_data.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PFX0,
      ST_PFX1,
      ST_HEX,
      ST_CR,
      ST_LF
   } state_t;

   function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble, input logic uppercase);
      logic [7:0] n8;
      n8 = {4'h0, nibble};
      if (nibble < 4'd10)
         return CHAR_0 + n8;
      else if (uppercase)
         return CHAR_A_UC + n8 - 8'd10;
      else
         return CHAR_A_LC + n8 - 8'd10;
   endfunction

endpackage

// File: rtl/uart_hex_formatter.sv
// Turns a binary word into an ASCII hex line ("0x", digits MSB-first, CR LF),
// streamed one byte per handshake to a UART emitter.
module uart_hex_formatter
   import uart_hex_formatter_pkg::*;
#(
   parameter int WORD_WIDTH = 32,
   parameter int UPPERCASE  = 0,
   parameter int PREFIX     = 1,
   parameter int EOL        = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [WORD_WIDTH-1:0] i_word,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic [7:0]            o_data,
   output logic                  o_valid,
   input  logic                  i_ready
);

   localparam int DIGITS = WORD_WIDTH / 4;
   localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);
   localparam logic UC = (UPPERCASE != 0);

   state_t                state, state_n;
   logic [WORD_WIDTH-1:0] shreg, shreg_n;
   logic [WORD_WIDTH-1:0] shifted;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic [7:0]            data, data_n;
   logic                  valid, valid_n;
   logic                  ready, ready_n;
   logic                  accept, xfer;

   assign o_ready = ready;
   assign o_valid = valid;
   assign o_data  = data;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_IDLE;
         shreg <= '0;
         cnt   <= '0;
         data  <= '0;
         valid <= 1'b0;
         ready <= 1'b0;
      end else begin
         state <= state_n;
         shreg <= shreg_n;
         cnt   <= cnt_n;
         data  <= data_n;
         valid <= valid_n;
         ready <= ready_n;
      end
   end

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      cnt_n   = cnt;
      data_n  = data;
      valid_n = valid;
      ready_n = ready;
      accept  = ready & i_valid;
      xfer    = valid & i_ready;
      shifted = shreg << 4;

      case (state)
         ST_IDLE: begin
            // ready is low only on the first cycle after reset release
            ready_n = 1'b1;
            if (accept) begin
               shreg_n = i_word;
               cnt_n   = '0;
               ready_n = 1'b0;
               valid_n = 1'b1;
               if (PREFIX != 0) begin
                  state_n = ST_PFX0;
                  data_n  = CHAR_0;
               end else begin
                  state_n = ST_HEX;
                  data_n  = hex_to_ascii(i_word[WORD_WIDTH-1 -: 4], UC);
               end
            end
         end
         ST_PFX0: begin
            if (xfer) begin
               state_n = ST_PFX1;
               data_n  = CHAR_X;
            end
         end
         ST_PFX1: begin
            if (xfer) begin
               state_n = ST_HEX;
               data_n  = hex_to_ascii(shreg[WORD_WIDTH-1 -: 4], UC);
            end
         end
         ST_HEX: begin
            if (xfer) begin
               if (cnt == LAST_DIGIT) begin
                  if (EOL != 0) begin
                     state_n = ST_CR;
                     data_n  = CHAR_CR;
                  end else begin
                     state_n = ST_IDLE;
                     valid_n = 1'b0;
                     ready_n = 1'b1;
                  end
               end else begin
                  // digit on o_data is always the top nibble of shreg
                  cnt_n   = cnt + CNT_W'(1);
                  shreg_n = shifted;
                  data_n  = hex_to_ascii(shifted[WORD_WIDTH-1 -: 4], UC);
               end
            end
         end
         ST_CR: begin
            if (xfer) begin
               state_n = ST_LF;
               data_n  = CHAR_LF;
            end
         end
         ST_LF: begin
            if (xfer) begin
               state_n = ST_IDLE;
               valid_n = 1'b0;
               ready_n = 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            valid_n = 1'b0;
            ready_n = 1'b1;
         end
      endcase
   end

endmodule
